// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage feeding decode through a small PC+instruction buffer
//
// Ports:
//   clk, rst          : clock; asynchronous active-high reset
//   start_pc          : first fetch address, loaded while rst is high
//   enable            : allows new fetches; in-flight reads always complete
//   imem_addr/ren     : instruction memory read port (1-cycle read latency)
//   imem_rdata        : data for the address requested in the previous cycle
//   br_taken/target   : redirect from execute; flushes everything younger
//   if_valid/instr/pc : buffer head presented to decode
//   id_ready          : decode takes the head this cycle
module instr_fetch_unit #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              enable,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_ren,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready
);

    // Storage is always four slots so 2-bit pointers index it exactly;
    // only the first FIFO_DEPTH slots are ever used.
    localparam int SLOTS = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    logic [DATA_W-1:0] buf_instr [SLOTS];
    logic [ADDR_W-1:0] buf_pc    [SLOTS];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              room;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign if_valid = (count != '0);
    assign pop      = if_valid & id_ready;

    // A read issued now lands one edge after the in-flight one, so reserve a
    // slot for everything already buffered or in flight, minus this cycle's pop.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign room      = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = enable & ~br_taken & room & ~rst;

    assign imem_addr = fetch_pc;
    assign imem_ren  = issue;

    // Head is read from registered storage only; imem_rdata never reaches the outputs directly.
    assign if_instr = buf_instr[rd_ptr];
    assign if_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= start_pc;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (br_taken) begin
            // Redirect wins over everything: drop buffered entries, any
            // simultaneous pop, and the read whose data returns next cycle.
            fetch_pc <= br_target;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (inflight) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= inflight_pc;
                wr_ptr            <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({inflight, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] start_pc = '0;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ren;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready = 1'b0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_pc(start_pc), .enable(enable),
        .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM, one-cycle read latency.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: every issued address waits in order until delivered;
    // its data becomes visible two cycles after issue; redirect/reset discard all.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        int                cyc;
    } ent_t;
    ent_t              pend[$];
    logic [ADDR_W-1:0] exp_fetch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit   exp_v;
        bit   exp_ren;
        int   pop_n;
        ent_t e;
        chk("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        exp_v = (pend.size() > 0) && (pend[0].cyc + 2 <= cyc);
        chk("if_valid", 32'(if_valid), 32'(exp_v));
        if (exp_v) begin
            chk("if_pc", 32'(if_pc), 32'(pend[0].pc));
            chk("if_instr", if_instr, mem[pend[0].pc]);
        end
        pop_n   = (exp_v && id_ready) ? 1 : 0;
        exp_ren = enable && !br_taken && ((pend.size() - pop_n) < DEPTH);
        chk("imem_ren", 32'(imem_ren), 32'(exp_ren));
        if (br_taken) begin
            pend.delete();
            exp_fetch = br_target;
        end else begin
            if (pop_n == 1) e = pend.pop_front();
            if (exp_ren) begin
                e.pc  = exp_fetch;
                e.cyc = cyc;
                pend.push_back(e);
                exp_fetch = exp_fetch + 1'b1;
            end
        end
    endtask

    task automatic drive(input bit br, input logic [ADDR_W-1:0] tgt, input bit en, input bit rdy);
        br_taken  = br;
        br_target = tgt;
        enable    = en;
        id_ready  = rdy;
        #2;
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] spc);
        rst       = 1'b1;
        start_pc  = spc;
        br_taken  = 1'b0;
        br_target = '0;
        enable    = 1'b1;
        id_ready  = 1'b1;
        #1;
        chk("rst_async_valid", 32'(if_valid), 32'd0);
        chk("rst_async_ren", 32'(imem_ren), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_ren", 32'(imem_ren), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        rst = 1'b0;
        pend.delete();
        exp_fetch = spc;
        cyc = 0;
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = $urandom;
        for (int k = 0; k < 4; k++) mem[16 + k] = 32'hE3A00001 + 32'(k);

        // Straight-line program, decode always ready.
        do_reset(11'h010);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (c == 0) begin
                chk("t1_addr0", 32'(imem_addr), 32'h010);
                chk("t1_ren0", 32'(imem_ren), 32'd1);
            end
            if (c < 2) chk("t1_empty", 32'(if_valid), 32'd0);
            if (c >= 2 && c <= 5) begin
                chk("t1_valid", 32'(if_valid), 32'd1);
                chk("t1_pc", 32'(if_pc), 32'h010 + 32'(c - 2));
                chk("t1_instr", if_instr, 32'hE3A00001 + 32'(c - 2));
            end
            tick();
        end

        // Decode stalls in cycles 3..7.
        do_reset(11'h010);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, 1'b1, !(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) begin
                chk("t2_hold_pc", 32'(if_pc), 32'h011);
                chk("t2_hold_instr", if_instr, 32'hE3A00002);
                chk("t2_no_issue", 32'(imem_ren), 32'd0);
            end
            if (c == 9)  chk("t2_pc9", 32'(if_pc), 32'h012);
            if (c == 10) chk("t2_pc10", 32'(if_pc), 32'h013);
            tick();
        end

        // Redirect to 0x100 in cycle 4.
        do_reset(11'h010);
        for (int c = 0; c < 10; c++) begin
            drive(c == 4, 11'h100, 1'b1, 1'b1);
            if (c == 4) chk("t3_no_issue_br", 32'(imem_ren), 32'd0);
            if (c == 5 || c == 6) chk("t3_bubble", 32'(if_valid), 32'd0);
            if (c == 5) chk("t3_addr", 32'(imem_addr), 32'h100);
            if (c == 7) begin
                chk("t3_valid", 32'(if_valid), 32'd1);
                chk("t3_pc", 32'(if_pc), 32'h100);
            end
            tick();
        end

        // Address wrap.
        do_reset(11'h7FE);
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (c == 4) chk("t4_wrap_pc", 32'(if_pc), 32'h000);
            if (c == 5) chk("t4_wrap_pc1", 32'(if_pc), 32'h001);
            tick();
        end

        // enable low for cycles 4..7.
        do_reset(11'h010);
        for (int c = 0; c < 13; c++) begin
            drive(1'b0, '0, !(c >= 4 && c <= 7), 1'b1);
            if (c >= 4 && c <= 7) chk("t5_ren_off", 32'(imem_ren), 32'd0);
            if (c == 5)  chk("t5_inflight_pc", 32'(if_pc), 32'h013);
            if (c == 6)  chk("t5_drained", 32'(if_valid), 32'd0);
            if (c == 8)  chk("t5_resume_addr", 32'(imem_addr), 32'h014);
            if (c == 10) chk("t5_resume_pc", 32'(if_pc), 32'h014);
            tick();
        end

        // Asynchronous reset with a full buffer.
        do_reset(11'h010);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1, c < 2);
            if (c == 5) begin
                chk("t6_full_valid", 32'(if_valid), 32'd1);
                chk("t6_full_ren", 32'(imem_ren), 32'd0);
                do_reset(11'h020);
            end else begin
                tick();
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (c == 2) chk("t6_first_pc", 32'(if_pc), 32'h020);
            tick();
        end

        // Randomized traffic against the model.
        do_reset(11'($urandom_range(0, 2047)));
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 19) == 0, 11'($urandom_range(0, 2047)),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) do_reset(11'($urandom_range(0, 2047)));
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
